ws2812_match_frame: RTL and testbench

//  Parametrised colour-match game frame source for the WS2812 matrix driver. Holds a COLSxROWS target

---
 rtl/ws2812_match_frame_pkg.sv | 18 +
 rtl/ws2812_match_frame_if.sv | 23 ++
 rtl/ws2812_match_frame_cursor.sv | 50 +++++
 rtl/ws2812_match_frame.sv | 149 ++++++++++++++
 tb/tb_ws2812_match_frame.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_match_frame_pkg.sv
// Shared constants for the WS2812 colour-match frame source: key bit positions,
// sensor match encodings and status bit positions.
package ws2812_match_frame_pkg;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_PEEK  = 4;

  localparam logic [1:0] SIM_MISMATCH = 2'b00;
  localparam logic [1:0] SIM_MATCH    = 2'b01;

  localparam int unsigned PT_CUR  = 0;
  localparam int unsigned PT_PLAY = 1;
  localparam int unsigned PT_ALL  = 2;

endpackage

// File: rtl/ws2812_match_frame_if.sv
// Driver handshake and target-image write port of the match frame source.
interface ws2812_match_frame_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned CW = 8
);
  logic            cfg_start;
  logic            ws2812_start;
  logic [AW-1:0]   cfg_num;
  logic [3*CW-1:0] cfg_data;
  logic            tgt_we;
  logic [AW-1:0]   tgt_addr;
  logic [3*CW-1:0] tgt_data;

  modport master (
    output cfg_start, tgt_we, tgt_addr, tgt_data,
    input  ws2812_start, cfg_num, cfg_data
  );

  modport slave (
    input  cfg_start, tgt_we, tgt_addr, tgt_data,
    output ws2812_start, cfg_num, cfg_data
  );
endinterface

// File: rtl/ws2812_match_frame_cursor.sv
// Matrix cursor: decodes one-hot direction keys and wraps within the current row/column.
module ws2812_match_frame_cursor
  import ws2812_match_frame_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8,
  localparam int unsigned AW = $clog2(COLS * ROWS)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [3:0]    key,
  output logic [AW-1:0] cursor,
  output logic          move
);

  localparam int unsigned CB = $clog2(COLS);
  localparam int unsigned RB = $clog2(ROWS);

  logic [CB-1:0] col_q, col_d;
  logic [RB-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    // Chorded keys are ignored entirely.
    move  = $onehot(key);
    if (move) begin
      unique case (1'b1)
        key[KEY_UP]:    row_d = (row_q == '0) ? RB'(ROWS - 1) : row_q - RB'(1);
        key[KEY_DOWN]:  row_d = (row_q == RB'(ROWS - 1)) ? '0 : row_q + RB'(1);
        key[KEY_LEFT]:  col_d = (col_q == '0) ? CB'(COLS - 1) : col_q - CB'(1);
        key[KEY_RIGHT]: col_d = (col_q == CB'(COLS - 1)) ? '0 : col_q + CB'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign cursor = AW'(row_q) * AW'(COLS) + AW'(col_q);

endmodule

// File: rtl/ws2812_match_frame.sv
// Colour-match game frame source: target image RAM, cursor, solved map and per-pixel
// composition for the WS2812 matrix driver.
module ws2812_match_frame
  import ws2812_match_frame_pkg::*;
#(
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned CW           = 8,
  parameter int unsigned BRIGHT_SHIFT = 3,
  parameter int unsigned WAIT_CYCLES  = 1_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  localparam int unsigned NPIX = COLS * ROWS,
  localparam int unsigned AW   = $clog2(NPIX)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  ws2812_match_frame_if.slave  bus,
  input  logic [4:0]           key,
  input  logic                 c_ok,
  input  logic                 sample_valid,
  input  logic [1:0]           similar_flag,
  input  logic [CW-1:0]        data_r,
  input  logic [CW-1:0]        data_g,
  input  logic [CW-1:0]        data_b,
  output logic [CW-1:0]        set_r,
  output logic [CW-1:0]        set_g,
  output logic [CW-1:0]        set_b,
  output logic [2:0]           point,
  output logic [AW:0]          solved_cnt
);

  localparam int unsigned WW = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES);
  localparam int unsigned PW = 3 * CW;

  logic [AW-1:0]   cfg_num_q, cfg_num_d, cursor;
  logic [PW-1:0]   cfg_data_q, cfg_data_d, pix;
  logic            start_q, start_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic            play_q, play_d;
  logic [NPIX-1:0] solved_q, solved_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            move;
  logic [PW-1:0]   tgt_mem [NPIX];

  function automatic logic [PW-1:0] dim(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    for (int c = 0; c < 3; c++) r[c*CW +: CW] = p[c*CW +: CW] >> BRIGHT_SHIFT;
    return r;
  endfunction

  ws2812_match_frame_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (key[3:0]),
    .cursor  (cursor),
    .move    (move)
  );

  // Contents deliberately survive reset; reads of a just-written address see the old word.
  always_ff @(posedge sys_clk) begin
    if (bus.tgt_we && ({1'b0, bus.tgt_addr} < (AW + 1)'(NPIX))) begin
      tgt_mem[bus.tgt_addr] <= bus.tgt_data;
    end
  end

  always_comb begin
    pix = '0;
    if (cfg_num_q == cursor && play_q && blink_on_q) pix = {data_g, data_r, data_b};
    else if (!play_q || solved_q[cfg_num_q])         pix = tgt_mem[cfg_num_q];
    cfg_data_d = dim(pix);

    cfg_num_d = cfg_num_q;
    if (bus.cfg_start) cfg_num_d = (cfg_num_q == AW'(NPIX - 1)) ? '0 : cfg_num_q + AW'(1);

    wait_d  = (wait_q == WW'(WAIT_CYCLES)) ? wait_q : wait_q + WW'(1);
    start_d = (wait_q == WW'(WAIT_CYCLES - 1)) ||
              (wait_q == WW'(WAIT_CYCLES) && bus.cfg_start && cfg_num_q == AW'(NPIX - 1));

    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_on_d  = blink_on_q;
    if (move) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end

    play_d = play_q ^ c_ok;

    // Indexed by the pre-move cursor, so a simultaneous move never redirects the sample.
    solved_d = solved_q;
    cnt_d    = cnt_q;
    if (sample_valid) begin
      if (similar_flag == SIM_MATCH && !solved_q[cursor]) begin
        solved_d[cursor] = 1'b1;
        cnt_d            = cnt_q + (AW + 1)'(1);
      end else if (similar_flag == SIM_MISMATCH && solved_q[cursor]) begin
        solved_d[cursor] = 1'b0;
        cnt_d            = cnt_q - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cfg_num_q   <= '0;
      cfg_data_q  <= '0;
      start_q     <= 1'b0;
      wait_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      play_q      <= 1'b0;
      solved_q    <= '0;
      cnt_q       <= '0;
    end else begin
      cfg_num_q   <= cfg_num_d;
      cfg_data_q  <= cfg_data_d;
      start_q     <= start_d;
      wait_q      <= wait_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      play_q      <= play_d;
      solved_q    <= solved_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    point          = '0;
    point[PT_ALL]  = (cnt_q == (AW + 1)'(NPIX));
    point[PT_PLAY] = play_q;
    point[PT_CUR]  = solved_q[cursor];
    {set_g, set_r, set_b} = '0;
    if (key[KEY_PEEK]) {set_g, set_r, set_b} = tgt_mem[cursor];
  end

  assign bus.cfg_num      = cfg_num_q;
  assign bus.cfg_data     = cfg_data_q;
  assign bus.ws2812_start = start_q;
  assign solved_cnt       = cnt_q;

endmodule

// File: tb/tb_ws2812_match_frame.sv
// Bench for ws2812_match_frame: 8x8 instance against a spec-level model, plus a 5x3 instance.
module tb_ws2812_match_frame;

  localparam int W8 = 200;
  localparam int B8 = 6;
  localparam int W5 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, rst5 = 1'b1;
  logic [4:0] key8 = '0, key5 = '0;
  logic       c_ok8 = 1'b0, sv8 = 1'b0;
  logic [1:0] sim8 = '0;
  logic [7:0] dr = '0, dg = '0, db = '0;
  logic [7:0] set_r8, set_g8, set_b8, set_r5, set_g5, set_b5;
  logic [2:0] point8, point5;
  logic [6:0] cnt8;
  logic [4:0] cnt5;
  logic       z1 = 1'b0;
  logic [1:0] z2 = '0;
  logic [7:0] z8 = '0;

  ws2812_match_frame_if #(.AW(6), .CW(8)) if8 ();
  ws2812_match_frame_if #(.AW(4), .CW(8)) if5 ();

  ws2812_match_frame #(
    .COLS(8), .ROWS(8), .CW(8), .BRIGHT_SHIFT(3), .WAIT_CYCLES(W8), .BLINK_CYCLES(B8)
  ) dut8 (
    .sys_clk(clk), .sys_rst(rst8), .bus(if8), .key(key8), .c_ok(c_ok8),
    .sample_valid(sv8), .similar_flag(sim8), .data_r(dr), .data_g(dg), .data_b(db),
    .set_r(set_r8), .set_g(set_g8), .set_b(set_b8), .point(point8), .solved_cnt(cnt8)
  );

  ws2812_match_frame #(
    .COLS(5), .ROWS(3), .CW(8), .BRIGHT_SHIFT(3), .WAIT_CYCLES(W5), .BLINK_CYCLES(8)
  ) dut5 (
    .sys_clk(clk), .sys_rst(rst5), .bus(if5), .key(key5), .c_ok(z1),
    .sample_valid(z1), .similar_flag(z2), .data_r(z8), .data_g(z8), .data_b(z8),
    .set_r(set_r5), .set_g(set_g5), .set_b(set_b5), .point(point5), .solved_cnt(cnt5)
  );

  int total = 0, bad = 0;

  // Reference model state for the 8x8 instance
  logic [23:0] m_tgt [64];
  bit          m_solved [64];
  int          m_cnt, m_row, m_col, m_cfgnum, m_wait, m_bn;
  bit          m_play, m_bini, m_start;
  logic [23:0] m_cfgdata;

  typedef struct { logic [4:0] key; int idx; } mv_t;
  typedef struct { logic [1:0] sim; int cnt; } sv_t;
  mv_t mv_tab [7];
  sv_t sv_tab [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] dim(input logic [23:0] p);
    return {p[23:16] >> 3, p[15:8] >> 3, p[7:0] >> 3};
  endfunction

  function automatic logic [23:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, a ^ 8'hA5, 8'(i * 5 + 1)};
  endfunction

  task automatic model_step();
    int cur;
    bit bl;
    logic [23:0] pix;
    if (rst8) begin
      m_cfgnum = 0; m_cfgdata = '0; m_start = 0; m_wait = 0; m_row = 0; m_col = 0;
      m_play = 0; m_bini = 0; m_bn = 0; m_cnt = 0;
      for (int i = 0; i < 64; i++) m_solved[i] = 0;
    end else begin
      cur = m_row * 8 + m_col;
      bl  = m_bini ^ (((m_bn / B8) % 2) == 1);
      if (m_cfgnum == cur && m_play && bl)     pix = {dg, dr, db};
      else if (!m_play || m_solved[m_cfgnum]) pix = m_tgt[m_cfgnum];
      else                                     pix = '0;
      m_cfgdata = dim(pix);
      m_start = (m_wait == W8 - 1) || (m_wait == W8 && if8.cfg_start && m_cfgnum == 63);
      if (m_wait < W8) m_wait++;
      if (if8.cfg_start) m_cfgnum = (m_cfgnum + 1) % 64;
      if (sv8 && sim8 == 2'b01 && !m_solved[cur]) begin
        m_solved[cur] = 1; m_cnt++;
      end else if (sv8 && sim8 == 2'b00 && m_solved[cur]) begin
        m_solved[cur] = 0; m_cnt--;
      end
      if (if8.tgt_we) m_tgt[if8.tgt_addr] = if8.tgt_data;
      if (c_ok8) m_play = !m_play;
      if ($countones(key8[3:0]) == 1) begin
        if (key8[0]) m_row = (m_row + 7) % 8;
        if (key8[1]) m_row = (m_row + 1) % 8;
        if (key8[2]) m_col = (m_col + 7) % 8;
        if (key8[3]) m_col = (m_col + 1) % 8;
        m_bini = 1; m_bn = 0;
      end else begin
        m_bn++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_all(input string tag);
    int cur;
    logic [2:0] pe;
    cur = m_row * 8 + m_col;
    pe  = {m_cnt == 64, m_play, m_solved[cur]};
    chk({tag, ".cfg_num"}, 32'(if8.cfg_num), m_cfgnum);
    chk({tag, ".cfg_data"}, 32'(if8.cfg_data), 32'(m_cfgdata));
    chk({tag, ".start"}, 32'(if8.ws2812_start), 32'(m_start));
    chk({tag, ".point"}, 32'(point8), 32'(pe));
    chk({tag, ".solved_cnt"}, 32'(cnt8), m_cnt);
    chk({tag, ".set"}, 32'({set_g8, set_r8, set_b8}), key8[4] ? 32'(m_tgt[cur]) : 32'd0);
  endtask

  initial begin
    int first_hi, n_hi;
    if8.cfg_start = 0; if8.tgt_we = 0; if8.tgt_addr = '0; if8.tgt_data = '0;
    if5.cfg_start = 0; if5.tgt_we = 0; if5.tgt_addr = '0; if5.tgt_data = '0;
    mv_tab = '{'{5'b00100, 7}, '{5'b00001, 63}, '{5'b01000, 56}, '{5'b00010, 0},
               '{5'b00011, 0}, '{5'b00010, 8}, '{5'b01000, 9}};
    sv_tab = '{'{2'b01, 1}, '{2'b01, 1}, '{2'b00, 0}, '{2'b10, 0}, '{2'b01, 1}, '{2'b11, 1}};

    // Reset, power-up delay, target load during the wait
    repeat (3) cyc();
    chk("rst.cfg_num", 32'(if8.cfg_num), 0);
    chk("rst.cfg_data", 32'(if8.cfg_data), 0);
    chk("rst.point", 32'(point8), 0);
    chk("rst.cnt", 32'(cnt8), 0);
    rst8 = 0;
    first_hi = -1; n_hi = 0;
    for (int k = 1; k <= W8 + 2; k++) begin
      if8.tgt_we = (k <= 64); if8.tgt_addr = 6'(k - 1); if8.tgt_data = 24'h00FF00;
      cyc();
      if (if8.ws2812_start) begin
        n_hi++;
        if (first_hi < 0) first_hi = k;
      end
    end
    if8.tgt_we = 0;
    chk("start_first", first_hi, W8);
    chk("start_width", n_hi, 1);
    chk("idle.cfg_num", 32'(if8.cfg_num), 0);

    // One frame of 64 pixels in preview
    chk("t2.data0", 32'(if8.cfg_data), 32'h001F00);
    for (int i = 0; i < 64; i++) begin
      if8.cfg_start = 1; cyc(); if8.cfg_start = 0;
      if (i == 63) begin
        chk("t2.start", 32'(if8.ws2812_start), 1);
        chk("t2.wrap", 32'(if8.cfg_num), 0);
      end
      cyc();
      chk("t2.data", 32'(if8.cfg_data), 32'h001F00);
      chk_all("t2");
    end
    chk("t2.start_end", 32'(if8.ws2812_start), 0);

    // Distinct image for cursor observation through the peek key
    for (int i = 0; i < 64; i++) begin
      if8.tgt_we = 1; if8.tgt_addr = 6'(i); if8.tgt_data = pat(i); cyc();
    end
    if8.tgt_we = 0;
    foreach (mv_tab[i]) begin
      key8 = mv_tab[i].key; cyc(); chk_all("mv");
      key8 = 5'b10000; cyc();
      chk("mv.peek", 32'({set_g8, set_r8, set_b8}), 32'(pat(mv_tab[i].idx)));
      chk_all("peek");
      key8 = 0;
    end

    // Solved map at cursor 9 in play mode
    c_ok8 = 1; cyc(); c_ok8 = 0;
    chk("play_on", 32'(point8[1]), 1);
    foreach (sv_tab[i]) begin
      sv8 = 1; sim8 = sv_tab[i].sim; cyc(); sv8 = 0;
      chk("sv.cnt", 32'(cnt8), sv_tab[i].cnt);
      chk("sv.point0", 32'(point8[0]), (sv_tab[i].cnt == 1) ? 1 : 0);
      chk_all("sv");
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if8.cfg_start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: key8 = 5'b0;
        1: key8 = 5'(1 << $urandom_range(0, 3));
        2: key8 = 5'($urandom);
        default: key8 = 5'b10000;
      endcase
      c_ok8 = ($urandom_range(0, 15) == 0);
      sv8 = 1'($urandom_range(0, 1)); sim8 = 2'($urandom);
      dr = 8'($urandom); dg = 8'($urandom); db = 8'($urandom);
      if8.tgt_we = ($urandom_range(0, 7) == 0);
      if8.tgt_addr = 6'($urandom); if8.tgt_data = 24'($urandom);
      cyc();
      chk_all("rnd");
    end
    if8.cfg_start = 0; key8 = 0; c_ok8 = 0; sv8 = 0; if8.tgt_we = 0;

    // Solve every pixel, sampling while moving right
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sv8 = 1; sim8 = 2'b01; key8 = 5'b01000; cyc(); chk_all("solve");
      end
      sv8 = 0; key8 = 5'b00010; cyc(); chk_all("solve");
    end
    key8 = 0;
    chk("all.point2", 32'(point8[2]), 1);
    chk("all.cnt", 32'(cnt8), 64);

    // Reset in mid-frame
    if8.cfg_start = 1; repeat (3) cyc(); if8.cfg_start = 0;
    rst8 = 1; cyc();
    chk("mrst.cfg_num", 32'(if8.cfg_num), 0);
    chk("mrst.cfg_data", 32'(if8.cfg_data), 0);
    chk("mrst.start", 32'(if8.ws2812_start), 0);
    chk("mrst.point", 32'(point8), 0);
    chk("mrst.cnt", 32'(cnt8), 0);
    chk("mrst.set", 32'({set_g8, set_r8, set_b8}), 0);
    rst8 = 0;
    for (int k = 1; k <= W8; k++) begin
      if8.cfg_start = 1; cyc();
      chk("mrst.start_k", 32'(if8.ws2812_start), (k == W8) ? 1 : 0);
      chk_all("mrst");
    end
    if8.cfg_start = 0;

    // 5x3 instance: non-power-of-two wrap
    cyc(); rst5 = 0;
    for (int i = 0; i < 15; i++) begin
      if5.tgt_we = 1; if5.tgt_addr = 4'(i); if5.tgt_data = pat(i); cyc();
    end
    if5.tgt_we = 0;
    if5.cfg_start = 1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (i == 14) chk("c5.num14", 32'(if5.cfg_num), 14);
      if (i == 15) chk("c5.wrap", 32'(if5.cfg_num), 0);
    end
    if5.cfg_start = 0;
    key5 = 5'b01000; repeat (4) cyc();
    key5 = 5'b10000; cyc();
    chk("c5.idx4", 32'({set_g5, set_r5, set_b5}), 32'(pat(4)));
    key5 = 5'b01000; cyc();
    key5 = 5'b10000; cyc();
    chk("c5.right_wrap", 32'({set_g5, set_r5, set_b5}), 32'(pat(0)));
    key5 = 5'b01000; repeat (2) cyc();
    key5 = 5'b00001; cyc();
    key5 = 5'b10000; cyc();
    chk("c5.up_wrap", 32'({set_g5, set_r5, set_b5}), 32'(pat(12)));
    key5 = 0; cyc();
    chk("c5.peek_off", 32'({set_g5, set_r5, set_b5}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
